// File: rtl/alu_pkg.sv
// alu_pkg: ctrl encodings and FSM state type shared by alu_seq and its bench.
package alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRAV = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_ORI  = 4'b1010;
    localparam logic [3:0] ALU_SEQ  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;
    localparam logic [3:0] ALU_MULU = 4'b1110;
    localparam logic [3:0] ALU_DIVU = 4'b1111;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiply / restoring divide.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH:0] add_sum, rem_sh, rem_sub;
    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, b_q};
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        done_o  = busy_q && (cnt_q == CW'(WIDTH - 1));
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        if (start_i) begin
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = is_div_i;
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
        end else if (busy_q) begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = !done_o;
            // hi holds the partial remainder / upper product; lo shifts quotient bits in or multiplier bits out
            if (div_q) begin
                hi_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], !rem_sub[WIDTH]};
            end else begin
                {hi_d, lo_d} = lo_q[0] ? {add_sum, lo_q[WIDTH-1:1]} : {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
        end
    end
    assign busy_o = busy_q;
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU; single-cycle ops plus iterative mulu/divu with hi/lo results.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt,
    input  logic [15:0]      imm,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             dz_o
);
    state_e state_q, state_d;
    logic valid_q, valid_d, zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
    logic it_start, it_busy, it_done, sc_ovf;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, it_lo, it_hi, sc_res, sum, diff;
    logic [WIDTH+15:0] lui_w;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (it_start),
        .is_div_i(ctrl_i == ALU_DIVU),
        .a_i     (src1_i),
        .b_i     (src2_i),
        .busy_o  (it_busy),
        .done_o  (it_done),
        .lo_o    (it_lo),
        .hi_o    (it_hi)
    );

    always_comb begin
        sum    = src1_i + src2_i;
        diff   = src1_i - src2_i;
        lui_w  = {imm, {WIDTH{1'b0}}};
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ctrl_i)
            ALU_AND:  sc_res = src1_i & src2_i;
            ALU_OR:   sc_res = src1_i | src2_i;
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            ALU_NOR:  sc_res = ~(src1_i | src2_i);
            ALU_NAND: sc_res = ~(src1_i & src2_i);
            ALU_SLT:  sc_res = WIDTH'($signed(src1_i) < $signed(src2_i));
            ALU_SLTU: sc_res = WIDTH'(src1_i < src2_i);
            ALU_SLL:  sc_res = src2_i << shamt;
            ALU_SRLV: sc_res = src2_i >> src1_i[SHW-1:0];
            ALU_SRAV: sc_res = $signed(src2_i) >>> src1_i[SHW-1:0];
            ALU_LUI:  sc_res = lui_w[WIDTH+15:16];
            ALU_ORI:  sc_res = src1_i | WIDTH'(imm);
            ALU_SEQ:  sc_res = WIDTH'(src1_i == src2_i);
            ALU_DIVU: sc_res = '1;
            default:  sc_res = '0;
        endcase
    end

    assign ready_o = (state_q == IDLE) && !it_busy;

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        res_d    = res_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        it_start = 1'b0;
        case (state_q)
            IDLE: if (valid_i && ready_o) begin
                if (ctrl_i == ALU_MULU || (ctrl_i == ALU_DIVU && src2_i != '0)) begin
                    it_start = 1'b1;
                    state_d  = (ctrl_i == ALU_MULU) ? MUL : DIV;
                end else begin
                    // divide-by-zero lands here too: all-ones quotient, dividend as remainder
                    valid_d = 1'b1;
                    res_d   = sc_res;
                    hi_d    = (ctrl_i == ALU_DIVU) ? src1_i : '0;
                    ovf_d   = sc_ovf;
                    dz_d    = (ctrl_i == ALU_DIVU);
                end
            end
            MUL, DIV: if (it_done) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                res_d   = it_lo;
                hi_d    = it_hi;
                ovf_d   = 1'b0;
                dz_d    = 1'b0;
            end
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = res_q;
    assign result_hi_o = hi_q;
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;
    assign dz_o        = dz_q;
endmodule
